// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared constants and word types for the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int C_DEF_DATAWIDTH = 32;
  localparam int C_DEF_ADDRWIDTH = 5;
  localparam int C_DEF_NUM_READ  = 2;
  localparam int C_ZERO_IDX      = 0;

  typedef logic [C_DEF_ADDRWIDTH-1:0] reg_addr_t;
  typedef logic [C_DEF_DATAWIDTH-1:0] reg_data_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Write, read-port and scoreboard signals of the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH = C_DEF_DATAWIDTH,
  parameter int ADDRWIDTH = C_DEF_ADDRWIDTH,
  parameter int NUM_READ  = C_DEF_NUM_READ
);

  logic                          wr_en;
  logic [ADDRWIDTH-1:0]          wr_addr;
  logic [DATAWIDTH-1:0]          wr_data;
  logic [NUM_READ-1:0]           rd_en;
  logic [NUM_READ*ADDRWIDTH-1:0] rd_addr;
  logic [NUM_READ*DATAWIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]           rd_valid;
  logic [NUM_READ-1:0]           rd_busy;
  logic                          busy_set;
  logic [ADDRWIDTH-1:0]          busy_addr;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, busy_set, busy_addr,
    input  rd_data, rd_valid, rd_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, busy_set, busy_addr,
    output rd_data, rd_valid, rd_busy
  );

endinterface : regfile_mp_if
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Pending-write busy bits with per-read-port registered lookup.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRWIDTH = C_DEF_ADDRWIDTH,
  parameter int NUM_READ  = C_DEF_NUM_READ,
  parameter int ZERO_REG  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          busy_set,
  input  logic [ADDRWIDTH-1:0]          busy_addr,
  input  logic                          wr_en,
  input  logic [ADDRWIDTH-1:0]          wr_addr,
  input  logic [NUM_READ-1:0]           rd_en,
  input  logic [NUM_READ*ADDRWIDTH-1:0] rd_addr,
  output logic [NUM_READ-1:0]           rd_busy
);

  localparam int C_DEPTH = 2**ADDRWIDTH;

  logic [C_DEPTH-1:0]  busy_q, busy_d;
  logic [NUM_READ-1:0] rd_busy_q, rd_busy_d;
  logic                set_ok;

  // Set is applied after clear so a newly issued producer supersedes the completing one.
  always_comb begin
    set_ok = busy_set && !(ZERO_REG != 0 && busy_addr == ADDRWIDTH'(C_ZERO_IDX));
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (set_ok) busy_d[busy_addr] = 1'b1;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_busy_port
    logic [ADDRWIDTH-1:0] addr;
    assign addr = rd_addr[k*ADDRWIDTH +: ADDRWIDTH];
    // Same-edge completion is visible, same-edge issue is not.
    assign rd_busy_d[k] = rd_en[k] ? (busy_q[addr] & ~(wr_en && wr_addr == addr))
                                   : rd_busy_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rd_busy_q <= '0;
    end else begin
      busy_q    <= busy_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_busy = rd_busy_q;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with zero register and busy scoreboard.
//            REGFILE_WRITE_FIRST_EN selects write-first collisions (default read-first).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH = C_DEF_DATAWIDTH,
  parameter int ADDRWIDTH = C_DEF_ADDRWIDTH,
  parameter int NUM_READ  = C_DEF_NUM_READ,
  parameter int ZERO_REG  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);

  localparam int C_DEPTH = 2**ADDRWIDTH;

  logic [DATAWIDTH-1:0]          mem_q [C_DEPTH];
  logic [DATAWIDTH-1:0]          mem_d [C_DEPTH];
  logic [NUM_READ*DATAWIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_READ-1:0]           rd_valid_q, rd_valid_d;
  logic                          wr_accept;

  always_comb begin
    wr_accept = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == ADDRWIDTH'(C_ZERO_IDX));
    mem_d = mem_q;
    if (wr_accept) mem_d[bus.wr_addr] = bus.wr_data;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd_port
    logic [ADDRWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0] rdata;
    always_comb begin
      addr  = bus.rd_addr[k*ADDRWIDTH +: ADDRWIDTH];
      rdata = mem_q[addr];
`ifdef REGFILE_WRITE_FIRST_EN
      if (bus.wr_en && bus.wr_addr == addr) rdata = bus.wr_data;
`endif
      // Zero register wins over the bypass as well.
      if (ZERO_REG != 0 && addr == ADDRWIDTH'(C_ZERO_IDX)) rdata = '0;
    end
    assign rd_data_d[k*DATAWIDTH +: DATAWIDTH] =
      bus.rd_en[k] ? rdata : rd_data_q[k*DATAWIDTH +: DATAWIDTH];
  end

  assign rd_valid_d = bus.rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

  regfile_scoreboard #(
    .ADDRWIDTH (ADDRWIDTH),
    .NUM_READ  (NUM_READ),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy_set  (bus.busy_set),
    .busy_addr (bus.busy_addr),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .rd_en     (bus.rd_en),
    .rd_addr   (bus.rd_addr),
    .rd_busy   (bus.rd_busy)
  );

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed self-checking bench for regfile_mp with four read ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int C_DW = 32;
  localparam int C_AW = 5;
  localparam int C_NR = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  regfile_mp_if #(.DATAWIDTH(C_DW), .ADDRWIDTH(C_AW), .NUM_READ(C_NR)) bus ();

  regfile_mp #(
    .DATAWIDTH (C_DW),
    .ADDRWIDTH (C_AW),
    .NUM_READ  (C_NR),
    .ZERO_REG  (1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_en     = '0;
    bus.rd_addr   = '0;
    bus.busy_set  = 1'b0;
    bus.busy_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input reg_addr_t a, input reg_data_t d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic set_rd(input int k, input reg_addr_t a);
    bus.rd_en[k] = 1'b1;
    bus.rd_addr[k*C_AW +: C_AW] = a;
  endtask

  function automatic reg_data_t port_data(input int k);
    return bus.rd_data[k*C_DW +: C_DW];
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    check("reset_rd_data",  bus.rd_data,  '0);
    check("reset_rd_valid", bus.rd_valid, '0);
    check("reset_rd_busy",  bus.rd_busy,  '0);

    // Basic write then read with latency one, then hold with valid dropping
    set_wr(5'd7, 32'h1234_5678);
    tick();
    idle();
    set_rd(0, 5'd7);
    tick();
    check("basic_data",  port_data(0), 32'h1234_5678);
    check("basic_valid", bus.rd_valid, 4'b0001);
    idle();
    tick();
    check("basic_hold_data",  port_data(0), 32'h1234_5678);
    check("basic_hold_valid", bus.rd_valid, 4'b0000);

    // Zero register: dropped write, collision read, busy ignored
    set_wr(5'd0, 32'hFFFF_FFFF);
    set_rd(1, 5'd0);
    tick();
    check("zero_collide_p1", port_data(1), 32'h0);
    idle();
    bus.busy_set  = 1'b1;
    bus.busy_addr = 5'd0;
    tick();
    idle();
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    tick();
    check("zero_p0",   port_data(0), 32'h0);
    check("zero_p1",   port_data(1), 32'h0);
    check("zero_busy", bus.rd_busy[1:0], 2'b00);

    // Read/write collision on r3
    idle();
    set_wr(5'd3, 32'h1111_1111);
    tick();
    idle();
    set_wr(5'd3, 32'hA5A5_A5A5);
    set_rd(1, 5'd3);
    tick();
`ifdef REGFILE_WRITE_FIRST_EN
    check("collide_p1", port_data(1), 32'hA5A5_A5A5);
`else
    check("collide_p1", port_data(1), 32'h1111_1111);
`endif
    idle();
    set_rd(1, 5'd3);
    tick();
    check("collide_after", port_data(1), 32'hA5A5_A5A5);

    // Scoreboard sequence on r9
    idle();
    bus.busy_set  = 1'b1;
    bus.busy_addr = 5'd9;
    tick();
    idle();
    set_rd(0, 5'd9);
    tick();
    check("sb_set", bus.rd_busy[0], 1'b1);
    idle();
    set_rd(0, 5'd9);
    set_wr(5'd9, 32'h0000_0099);
    tick();
    check("sb_clear_same_edge", bus.rd_busy[0], 1'b0);
    idle();
    set_rd(0, 5'd9);
    tick();
    check("sb_cleared", bus.rd_busy[0], 1'b0);
    idle();
    set_rd(0, 5'd9);
    bus.busy_set  = 1'b1;
    bus.busy_addr = 5'd9;
    tick();
    check("sb_set_not_visible", bus.rd_busy[0], 1'b0);
    idle();
    set_wr(5'd9, 32'h0000_0009);
    tick();
    idle();
    set_wr(5'd9, 32'h0000_0010);
    bus.busy_set  = 1'b1;
    bus.busy_addr = 5'd9;
    tick();
    idle();
    set_rd(0, 5'd9);
    tick();
    check("sb_set_wins", bus.rd_busy[0], 1'b1);
    idle();
    tick();
    check("sb_hold", bus.rd_busy[0], 1'b1);

    // Multi-port: r1..r4 = 1..4 read on all ports at once
    for (int i = 1; i <= 4; i++) begin
      idle();
      set_wr(reg_addr_t'(i), reg_data_t'(i));
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) set_rd(k, reg_addr_t'(k + 1));
    tick();
    check("mp_data",  bus.rd_data, {32'd4, 32'd3, 32'd2, 32'd1});
    check("mp_valid", bus.rd_valid, 4'b1111);

    // Asynchronous reset mid-clock after r5 is written and read
    idle();
    set_wr(5'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    set_rd(0, 5'd5);
    set_rd(1, 5'd9);
    tick();
    check("pre_reset_data", port_data(0), 32'hDEAD_BEEF);
    check("pre_reset_busy", bus.rd_busy[1], 1'b1);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rd_data",  bus.rd_data,  '0);
    check("async_rd_valid", bus.rd_valid, '0);
    check("async_rd_busy",  bus.rd_busy,  '0);
    tick();
    rst_n = 1'b1;
    set_rd(0, 5'd5);
    set_rd(1, 5'd9);
    tick();
    check("post_reset_r5",    port_data(0), 32'h0);
    check("post_reset_valid", bus.rd_valid, 4'b0011);
    check("post_reset_busy",  bus.rd_busy[1], 1'b0);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_mp
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file with a pending-write scoreboard, intended as the next-generation integer register file of the RISC-V core.
- Generalises width, depth and read-port count.
- Adds asynchronous reset, a hardwired zero register, per-port read enables with a valid strobe, and per-register busy bits used by issue logic to detect RAW hazards.

Parameters:
- DATAWIDTH, 32, width of each register in bits.
- ADDRWIDTH, 5, register address width; depth = 2**ADDRWIDTH.
- NUM_READ, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDRWIDTH  write address.
- wr_data  input  DATAWIDTH  write data.
- rd_en  input  NUM_READ  per-port read enable.
- rd_addr  input  NUM_READ*ADDRWIDTH  packed read addresses; port k at bits [k*ADDRWIDTH +: ADDRWIDTH].
- rd_data  output  NUM_READ*DATAWIDTH  packed registered read data; port k at bits [k*DATAWIDTH +: DATAWIDTH].
- rd_valid  output  NUM_READ  registered copy of rd_en.
- rd_busy  output  NUM_READ  registered busy status of the address read on each port.
- busy_set  input  1  marks busy_addr as awaiting a write (instruction issued).
- busy_addr  input  ADDRWIDTH  destination register being allocated.

Behaviour:
- Reset, asynchronous on rst_n low:
  - all registers = 0, all busy bits = 0.
  - rd_data = 0, rd_valid = 0, rd_busy = 0.
  - Reset deasserted mid-operation: the first edge after release behaves normally; no writes are lost except those sampled while rst_n was low.
- Write: on the edge with wr_en=1, mem[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: latency 1 cycle.
  - On an edge with rd_en[k]=1: rd_data[k] <= value of mem[rd_addr[k]], rd_valid[k] <= 1.
  - With rd_en[k]=0: rd_data[k] holds its previous value and rd_valid[k] <= 0.
  - Ports are fully independent; any number may read the same address in the same cycle.
- Read/write collision (same edge, rd_addr[k]=wr_addr, wr_en=1): the result is governed by the optional feature below.
- Zero register: with ZERO_REG=1, reading address 0 always returns 0, including under collision.
- Scoreboard:
  - busy_set=1 sets busy[busy_addr]; wr_en=1 clears busy[wr_addr].
  - Same address in the same cycle: set wins (a new producer supersedes the completing one).
  - busy_set to address 0 is ignored when ZERO_REG=1.
  - busy_set without wr_en and wr_en without busy set are both legal; clearing a non-busy bit is a no-op.
- rd_busy[k], updated only when rd_en[k]=1 (holds otherwise):
  - rd_busy[k] <= busy[addr] & ~(wr_en & wr_addr==addr).
  - The same-cycle clear is visible; a same-cycle set is NOT visible.
- Width rules: no truncation or extension; all data paths are exactly DATAWIDTH. Out-of-range addresses are impossible by construction.

Optional Feature:
- Macro: REGFILE_WRITE_FIRST_EN.
- Defined: write-first. A same-edge read of the address being written returns wr_data (internal bypass mux per read port).
- Undefined: read-first. A same-edge read returns the old contents, and the new value is visible from the next read.
- The zero-register rule overrides both modes.

Decomposition:
- Shared package regfile_pkg:
  - default DATAWIDTH/ADDRWIDTH constants.
  - typedef for register address and data words.
  - localparam for the zero-register index.
- Sub-module regfile_scoreboard: busy-bit vector, set/clear priority and per-port busy lookup, instantiated once.
- Storage array, read ports and bypass stay in regfile_mp.

Test Plan:
- Reset: assert rst_n=0 mid-clock after writing 0xDEADBEEF to r5 -> rd_data and rd_valid are 0 immediately; a subsequent read of r5 returns 0x00000000.
- Basic write/read: write 0x12345678 to r7, next cycle rd_en[0]=1 on r7 -> rd_data[0]=0x12345678 and rd_valid[0]=1 one cycle later; rd_en low next cycle -> data held, rd_valid[0]=0.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0, then read r0 on both ports -> 0x00000000; busy_set on r0 -> rd_busy=0.
- Collision: write 0xA5A5A5A5 to r3 while port 1 reads r3, which holds 0x11111111 -> port 1 returns 0xA5A5A5A5 with REGFILE_WRITE_FIRST_EN, 0x11111111 without.
- Scoreboard sequence:
  - busy_set r9, then read r9 -> rd_busy=1.
  - Write r9 while reading r9 -> rd_busy=0.
  - busy_set and wr_en both on r9 in the same cycle, then read -> rd_busy=1.
- Multi-port (NUM_READ=4): all four ports read r1..r4, preloaded with 1..4, in one cycle -> rd_data packs 1,2,3,4 in port order; all rd_valid bits = 1.
